// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and helpers for the K=3 rate-1/2 (7,5) code
package viterbi_pkg;

    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;
    localparam int NUM_STATES = 4;

    typedef logic [1:0] state_t;
    typedef logic [1:0] symbol_t;

    // Register bits are {u, b1, b0}; each output is the parity of the generator taps.
    function automatic symbol_t expected_symbol(input logic u, input state_t state);
        logic [2:0] reg_bits;
        reg_bits = {u, state};
        return {^(reg_bits & G0), ^(reg_bits & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input symbol_t a, input symbol_t b);
        symbol_t x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// rtl/viterbi_decoder_if.sv - symbol input / decoded bit output bundle
interface viterbi_decoder_if;
    import viterbi_pkg::*;

    logic    enable;
    symbol_t d_in;
    logic    d_out;

    modport master (output enable, output d_in, input d_out);
    modport slave  (input enable, input d_in, output d_out);

endinterface

// File: rtl/acs_unit.sv
// rtl/acs_unit.sv - saturating add-compare-select for one trellis state
module acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    // Ties resolve toward predecessor 0, so only a strictly smaller cand1 selects it.
    always_comb begin
        sum0  = {1'b0, pm0_i} + (PM_W+1)'(bm0_i);
        sum1  = {1'b0, pm1_i} + (PM_W+1)'(bm1_i);
        cand0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
        cand1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
        dec_o = (cand1 < cand0);
        pm_o  = dec_o ? cand1 : cand0;
    end

endmodule

// File: rtl/encoder.sv
// rtl/encoder.sv - companion (7,5) convolutional encoder producing decoder symbols
module encoder
    import viterbi_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    enable_i,
    input  logic    d_in,
    output logic    valid_o,
    output symbol_t d_out
);

    state_t  state_q, state_d;
    symbol_t d_out_q, d_out_d;
    logic    valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        d_out_d = d_out_q;
        valid_d = enable_i;
        if (enable_i) begin
            d_out_d = expected_symbol(d_in, state_q);
            state_d = {d_in, state_q[1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            d_out_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign d_out   = d_out_q;

endmodule

// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - 4-state hard-decision Viterbi decoder with register-exchange survivors
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int TB_LEN = 16,
    parameter int PM_W   = 6
) (
    input logic               clk,
    input logic               rst,
    viterbi_decoder_if.slave  dec
);

    localparam int CNT_W = $clog2(TB_LEN);
    localparam logic [PM_W-1:0] PM_INIT = (PM_W >= 5) ? PM_W'(16) : {PM_W{1'b1}};

    logic [NUM_STATES-1:0][PM_W-1:0]   pm_q, pm_d, pm_acs;
    logic [NUM_STATES-1:0][TB_LEN-1:0] surv_q, surv_d;
    logic [NUM_STATES-1:0]             dec_bit;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic                              d_out_q, d_out_d;
    logic [PM_W-1:0]                   pm_min;
    state_t                            best;

    // Next state {u,b1} is reached from {b1,0} or {b1,1} with input u.
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam state_t NS = state_t'(s);
        localparam state_t P0 = {NS[0], 1'b0};
        localparam state_t P1 = {NS[0], 1'b1};

        logic [1:0] bm0;
        logic [1:0] bm1;

        assign bm0 = hamming2(dec.d_in, expected_symbol(NS[1], P0));
        assign bm1 = hamming2(dec.d_in, expected_symbol(NS[1], P1));

        acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (pm_acs[s]),
            .dec_o (dec_bit[s])
        );
    end

    always_comb begin
        state_t si;
        state_t pred;
        si   = '0;
        pred = '0;

        pm_min = pm_acs[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_acs[i] < pm_min) pm_min = pm_acs[i];
        end

        // Descending scan leaves the lowest index holding the minimum.
        best = '0;
        for (int i = NUM_STATES - 1; i >= 0; i--) begin
            if (pm_acs[i] == pm_min) best = state_t'(i);
        end

        pm_d    = pm_q;
        surv_d  = surv_q;
        cnt_d   = cnt_q;
        d_out_d = d_out_q;

        if (dec.enable) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                si        = state_t'(i);
                pred      = {si[0], dec_bit[i]};
                surv_d[i] = {surv_q[pred][TB_LEN-2:0], si[1]};
                pm_d[i]   = pm_acs[i] - pm_min;
            end
            // The survivor window is not yet full until TB_LEN-1 symbols have gone by.
            if (cnt_q == CNT_W'(TB_LEN - 1)) begin
                d_out_d = surv_d[best][TB_LEN-1];
            end else begin
                cnt_d   = cnt_q + 1'b1;
                d_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pm_q    <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
            surv_q  <= '0;
            cnt_q   <= '0;
            d_out_q <= 1'b0;
        end else begin
            pm_q    <= pm_d;
            surv_q  <= surv_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
        end
    end

    assign dec.d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - scoreboard bench for viterbi_decoder and its companion encoder
module tb_viterbi_decoder;
    import viterbi_pkg::*;

    localparam int TB_LEN = 16;
    localparam int N_BITS = 256;

    typedef struct {
        logic       dec;
        logic [1:0] enc_d;
        logic       enc_v;
        int         idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_en;
    logic       enc_din;
    logic       enc_valid;
    logic [1:0] enc_dout;

    always #5 clk = ~clk;

    viterbi_decoder_if dif ();

    viterbi_decoder #(.TB_LEN(TB_LEN), .PM_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .dec (dif)
    );

    encoder u_enc (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enc_en),
        .d_in     (enc_din),
        .valid_o  (enc_valid),
        .d_out    (enc_dout)
    );

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    string      phase    = "init";
    bit         ref_bits [N_BITS];
    bit         stream_bits[$];
    logic [1:0] ref_state;
    int         sym_idx;
    logic       last_dec;
    logic [1:0] last_enc;
    logic [1:0] enc_tab [4];
    bit         enc_in_tab [4];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, expv);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("%s sym %0d dec d_out", phase, e.idx), {1'b0, dif.d_out}, {1'b0, e.dec});
                check($sformatf("%s sym %0d enc d_out", phase, e.idx), enc_dout, e.enc_d);
                check($sformatf("%s sym %0d enc valid", phase, e.idx), {1'b0, enc_valid}, {1'b0, e.enc_v});
            end
        end
    end

    task automatic drive_idle();
        dif.enable = 1'b0;
        dif.d_in   = 2'($urandom);
        enc_en     = 1'b0;
        enc_din    = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        exp_q.push_back('{dec: 1'b0, enc_d: 2'b00, enc_v: 1'b0, idx: -1});
        rst       = 1'b0;
        ref_state = 2'b00;
        sym_idx   = 0;
        stream_bits.delete();
        last_dec  = 1'b0;
        last_enc  = 2'b00;
    endtask

    task automatic send(input bit u, input logic [1:0] flip);
        logic [1:0] sym;
        logic       e;
        sym       = {u ^ ref_state[1] ^ ref_state[0], u ^ ref_state[0]};
        ref_state = {u, ref_state[1]};
        dif.enable = 1'b1;
        dif.d_in   = sym ^ flip;
        enc_en     = 1'b1;
        enc_din    = u;
        @(posedge clk); #1;
        stream_bits.push_back(u);
        e = (sym_idx < TB_LEN - 1) ? 1'b0 : stream_bits[sym_idx - TB_LEN + 1];
        exp_q.push_back('{dec: e, enc_d: sym, enc_v: 1'b1, idx: sym_idx});
        last_dec = e;
        last_enc = sym;
        sym_idx++;
        drive_idle();
    endtask

    task automatic gap();
        drive_idle();
        @(posedge clk); #1;
        exp_q.push_back('{dec: last_dec, enc_d: last_enc, enc_v: 1'b0, idx: -1});
    endtask

    task automatic run_stream(input int n, input int e1, input logic [1:0] m1,
                              input int e2, input logic [1:0] m2, input bit gaps);
        for (int k = 0; k < n; k++) begin
            logic [1:0] f;
            f = 2'b00;
            if (k == e1) f = m1;
            if (k == e2) f = m2;
            send(ref_bits[k], f);
            if (gaps && (k % 7 == 6)) repeat (3) gap();
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        enc_tab    = '{2'b11, 2'b10, 2'b00, 2'b01};
        enc_in_tab = '{1'b1, 1'b0, 1'b1, 1'b1};
        foreach (ref_bits[i]) ref_bits[i] = 1'($urandom);
        repeat (2) @(posedge clk);
        #1;

        phase = "encoder";
        do_reset();
        drain();
        for (int i = 0; i < 4; i++) begin
            enc_en  = 1'b1;
            enc_din = enc_in_tab[i];
            @(posedge clk); #1;
            check($sformatf("encoder table %0d d_out", i), enc_dout, enc_tab[i]);
            check($sformatf("encoder table %0d valid", i), {1'b0, enc_valid}, 2'b01);
        end
        enc_en  = 1'b0;
        enc_din = 1'b0;
        @(posedge clk); #1;
        check("encoder hold d_out", enc_dout, 2'b01);
        check("encoder valid drop", {1'b0, enc_valid}, 2'b00);

        phase = "clean";
        do_reset();
        run_stream(N_BITS, -1, 2'b00, -1, 2'b00, 1'b0);
        drain();

        phase = "single error";
        do_reset();
        run_stream(N_BITS, 40, 2'b01, -1, 2'b00, 1'b0);
        drain();

        phase = "two errors";
        do_reset();
        run_stream(N_BITS, 40, 2'b10, 60, 2'b01, 1'b0);
        drain();

        phase = "enable gaps";
        do_reset();
        run_stream(N_BITS, -1, 2'b00, -1, 2'b00, 1'b1);
        drain();

        phase = "mid reset";
        do_reset();
        run_stream(100, -1, 2'b00, -1, 2'b00, 1'b0);
        do_reset();
        foreach (ref_bits[i]) ref_bits[i] = 1'($urandom);
        run_stream(150, -1, 2'b00, -1, 2'b00, 1'b0);
        drain();

        check("scoreboard drained", (exp_q.size() == 0) ? 2'b01 : 2'b00, 2'b01);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/viterbi_decoder.md
VITERBI_DECODER -- requirements
Module: viterbi_decoder

Interface
REQ-001 SHALL have parameter TB_LEN, default 16, meaning survivor (traceback) depth in symbols, legal range 8..32.
REQ-002 SHALL have parameter PM_W, default 6, meaning path-metric width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: the symbol on d_in is valid this cycle.
REQ-006 SHALL have port d_in, input, 2 bits: received hard-decision symbol; bit1 = G0 output, bit0 = G1 output.
REQ-007 SHALL have port d_out, output, 1 bit: decoded data bit, registered.

Function
REQ-008 SHALL decode the K=3, rate-1/2 code with G0=111 (octal 7) and G1=101 (octal 5).
REQ-009 SHALL use 4 states, state = {b1,b0}, where b1 is the most recent input bit.
REQ-010 Input u in state {b1,b0} SHALL give next state {u,b1} and symbol {u^b1^b0, u^b0}.
REQ-011 Branch metric SHALL be the Hamming distance between d_in and the expected symbol (0..2).
REQ-012 On each edge with enable=1, add-compare-select SHALL run for all 4 states in parallel, one symbol per cycle.
- Each next state {u,b1} has predecessors {b1,0} and {b1,1}.
- Candidate = predecessor metric + branch metric.
- Smaller candidate wins; on a tie, predecessor {b1,0} wins.
REQ-013 Metric normalization: after ACS, the minimum new metric SHALL be subtracted from all 4 metrics, so the best state always holds 0.
REQ-014 Metrics SHALL saturate at 2^PM_W-1 and never wrap.
REQ-015 Survivor memory SHALL use register exchange: one TB_LEN-bit register per state.
- Each winning next state copies its predecessor's register, shifted left by one, with u appended as the LSB.
REQ-016 Best state = the state with metric 0 after normalization; on a tie, the lowest index wins.
REQ-017 On each enabled edge, d_out SHALL load the MSB of the best state's updated survivor register.
REQ-018 Latency: after the enabled edge that consumes symbol k+TB_LEN-1, d_out SHALL equal decoded bit k (0-based).
REQ-019 For the first TB_LEN-1 enabled symbols after reset, d_out SHALL be 0.
REQ-020 With enable=0, metrics, survivor registers and d_out SHALL hold; d_in SHALL be ignored.
REQ-021 There SHALL be no output valid signal; the consumer counts enabled cycles.

Reset
REQ-022 With rst=1 at a rising edge, the block SHALL set:
- metric of state 0 = 0;
- metrics of states 1..3 = 16, saturated to PM_W;
- all survivor registers = 0;
- d_out = 0;
- internal symbol counter = 0.
REQ-023 rst SHALL have priority over enable; a mid-stream reset SHALL discard all history and restart decoding from state 0.

Structure
REQ-024 A shared package viterbi_pkg SHALL hold:
- G0/G1 constants;
- state count (4);
- the expected-symbol function, used by both encoder and decoder.
REQ-025 A companion module encoder SHALL exist, with ports clk, rst, enable_i, d_in (1 bit), valid_o (1 bit), d_out (2 bits).
- Encoding: on an edge with enable_i=1, d_out <= {d_in^s1^s0, d_in^s0} and {s1,s0} <= {d_in,s1}.
- valid_o <= enable_i every edge.
- With enable_i=0, d_out and state hold.
- Reset clears s1, s0, d_out and valid_o to 0.
REQ-026 ACS for one next state SHALL be a sub-module acs_unit (inputs: two metrics, two branch metrics; outputs: new metric, decision bit), instantiated 4 times.

Verification
REQ-027 Encoder check: inputs 1,0,1,1 from reset -> d_out sequence 11,10,00,01, with valid_o following enable_i by 1 cycle.
REQ-028 Clean stream: 256 random bits encoded and decoded -> decoder output equals the input delayed by TB_LEN-1 enabled cycles, zero mismatches.
REQ-029 Single error: flip d_in[0] of symbol 40 -> zero output mismatches.
REQ-030 Two errors: flip one bit in each of symbols 40 and 60 (separation of TB_LEN or more symbols) -> zero mismatches.
REQ-031 Enable gaps: deassert enable for 3 cycles every 7 symbols -> d_out holds during the gaps, and the decoded sequence is unchanged from REQ-028.
REQ-032 Mid-stream reset at symbol 100, then a restart from encoder reset -> d_out is 0 for TB_LEN-1 symbols, then correct decoding resumes.
